adder_slice_seq: RTL
====================

Name: adder_slice_seq

Overview:
- Multi-cycle sequencer that performs a WIDTH-bit addition by time-sharing one SLICE-bit adder slice, least significant slice first, with a registered carry between slices.
- Area-reduced alternative to the fully parallel hierarchical adders; sits between an operand producer and a result consumer.
- Uses valid/ready handshakes on both sides.
- Result is modulo 2^WIDTH. Carry out of the MSB is dropped, matching the existing adder blocks.

Parameters:
- WIDTH, 32, operand/result width in bits; must be an integer multiple of SLICE.
- SLICE, 8, width of the shared adder slice in bits; NSLICE = WIDTH/SLICE, and NSLICE >= 2.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operand pair a/b is valid
- in_ready  output  1  block can accept operands
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B
- out_valid  output  1  sum is valid
- out_ready  input  1  consumer accepts sum
- sum  output  WIDTH  registered result
- busy  output  1  high in RUN or DONE

Behaviour:
- One clock; reset is asynchronous and active-low.
- Reset values: state=IDLE, in_ready=1, out_valid=0, busy=0, sum=0, slice counter=0, carry register=0, operand registers=0.
- FSM states and transitions:
  - IDLE: in_ready=1. On in_valid&&in_ready, capture a and b into internal registers, clear carry, clear counter, go to RUN.
  - RUN: in_ready=0. Each cycle, add slice[cnt] of A + slice[cnt] of B + carry. Write the SLICE-bit result into sum[cnt*SLICE +: SLICE] and register the carry out. Increment cnt. When cnt==NSLICE-1, go to DONE on that edge.
  - DONE: out_valid=1, sum stable. Stay in DONE until out_valid&&out_ready, then go to IDLE with out_valid=0.
- Latency: out_valid rises exactly NSLICE rising edges after the accepting edge (4 for the defaults).
  - Throughput: one operation per NSLICE+2 cycles.
- sum bits not yet written in RUN hold their previous values. sum is valid only while out_valid=1.
- Operand inputs a and b are don't-care outside the accepting cycle; changes during RUN have no effect.
- in_valid in RUN or DONE is ignored (in_ready=0); no operand is lost or queued.
- Backpressure: DONE holds out_valid and sum for any number of cycles while out_ready=0.
- out_ready asserted in IDLE or RUN has no effect.
- Final carry out of slice NSLICE-1 is discarded (wrap-around modulo 2^WIDTH).
- Reset asserted mid-operation returns to IDLE immediately (asynchronously). The partial result is discarded and no out_valid is produced.
- busy = (state != IDLE).

Optional Feature:
- Macro: ADDER_SLICE_SEQ_COUT_EN
- Defined:
  - Adds output port cout (1 bit), holding the registered carry out of the last slice. Valid while out_valid=1; reset value 0.
  - cout keeps its value until the next accept, then clears with the carry register.
- Undefined: no cout port; the final carry is discarded. All other behaviour is identical.

Test Plan:
- Basic carry chain: a=0x000000FF, b=0x00000001, out_ready=1 -> out_valid after 4 edges, sum=0x00000100; busy high for 5 cycles; back in IDLE next cycle.
- Full wrap: a=0xFFFFFFFF, b=0x00000001 -> sum=0x00000000.
  - With ADDER_SLICE_SEQ_COUT_EN: cout=1.
  - Then a=0x12345678, b=0x11111111 -> sum=0x23456789, cout=0.
- Backpressure: a=0x80008000, b=0x80008000, out_ready=0 for 10 cycles -> out_valid and sum=0x00010000 held stable; in_ready=0 throughout; one cycle after out_ready=1, out_valid=0 and in_ready=1.
- Ignored input: assert in_valid with a=0xDEADBEEF during RUN of 0x00000003+0x00000004 -> sum=0x00000007; the second operand is not captured and no second out_valid appears.
- Reset mid-RUN: accept 0x0F0F0F0F+0x01010101, deassert rst_n after 2 edges -> outputs immediately at reset values. After release, a new 0x00000001+0x00000001 gives sum=0x00000002 with no stale carry.
- Back-to-back: stream 8 random operand pairs with in_valid held high and random out_ready -> every sum equals (a+b) mod 2^32, in order, with no drop or duplicate.

Source files
------------

// File: rtl/adder_slice_seq.sv
// ---------------------------------------------------------------------------
// adder_slice_seq
//
// Adds two WIDTH-bit operands by reusing one SLICE-bit adder over NSLICE
// clock cycles, least significant slice first. The carry between slices is
// held in a register. The result wraps modulo 2^WIDTH.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   operand pair a/b is valid
//   in_ready   block can accept operands (high only in IDLE)
//   a, b       WIDTH-bit operands, sampled only on the accepting edge
//   out_valid  sum is valid (high only in DONE)
//   out_ready  consumer accepts sum
//   sum        registered WIDTH-bit result
//   busy       high while an operation is in flight (RUN or DONE)
//   cout       carry out of the last slice (only with ADDER_SLICE_SEQ_COUT_EN)
//
// Build option:
//   ADDER_SLICE_SEQ_COUT_EN  adds the cout output port. When this macro is
//                            not defined, the final carry is dropped.
// ---------------------------------------------------------------------------
module adder_slice_seq #(
  parameter int WIDTH = 32,
  parameter int SLICE = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             busy
`ifdef ADDER_SLICE_SEQ_COUT_EN
  ,
  output logic             cout
`endif
);

  localparam int NSLICE = WIDTH / SLICE;
  localparam int CNT_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NSLICE - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state_q;
  state_t             state_d;
  logic [WIDTH-1:0]   a_q;
  logic [WIDTH-1:0]   b_q;
  logic [WIDTH-1:0]   sum_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               carry_q;
  logic               accept;
  logic [SLICE-1:0]   a_slice;
  logic [SLICE-1:0]   b_slice;
  logic [SLICE:0]     slice_sum;

  assign accept = in_valid && in_ready;
  assign sum    = sum_q;

`ifdef ADDER_SLICE_SEQ_COUT_EN
  // After the last slice the carry register holds the final carry out, and it
  // is only cleared again by the next accept, so it can drive cout directly.
  assign cout = carry_q;
`endif

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic. The handshake outputs depend only on the current state,
  // so they are clean registered-state decodes.
  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b1;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid) begin
          state_d = RUN;
        end
      end
      RUN: begin
        if (cnt_q == LAST_CNT) begin
          state_d = DONE;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        busy    = 1'b0;
      end
    endcase
  end

  // Select the operand slices for the current step. A decoded mux with
  // constant part-selects avoids a variable-index shifter on the operands.
  always_comb begin
    a_slice = '0;
    b_slice = '0;
    for (int i = 0; i < NSLICE; i++) begin
      if (cnt_q == CNT_W'(i)) begin
        a_slice = a_q[i*SLICE +: SLICE];
        b_slice = b_q[i*SLICE +: SLICE];
      end
    end
  end

  // The one shared adder slice.
  assign slice_sum = {1'b0, a_slice} + {1'b0, b_slice} + {{SLICE{1'b0}}, carry_q};

  // Datapath registers. Operands are copied on accept so the producer may
  // change a/b freely while the operation runs. Slices of sum that have not
  // been rewritten yet keep their previous contents.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            a_q     <= a;
            b_q     <= b;
            cnt_q   <= '0;
            carry_q <= 1'b0;
          end
        end
        RUN: begin
          for (int i = 0; i < NSLICE; i++) begin
            if (cnt_q == CNT_W'(i)) begin
              sum_q[i*SLICE +: SLICE] <= slice_sum[SLICE-1:0];
            end
          end
          carry_q <= slice_sum[SLICE];
          cnt_q   <= (cnt_q == LAST_CNT) ? '0 : cnt_q + CNT_W'(1);
        end
        default: begin
        end
      endcase
    end
  end

endmodule
